// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: sensor-actuated four-light junction controller with flash mode
module traffic_phase_controller #(
    parameter int CNT_W    = 8,
    parameter int T_MAIN   = 20,
    parameter int T_TURN   = 8,
    parameter int T_SIDE   = 12,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 2,
    parameter int T_BLINK  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor_Mt,
    input  logic       sensor_S,
    input  logic       flash_en,
    output logic [2:0] light_M1,
    output logic [2:0] light_Mt,
    output logic [2:0] light_M2,
    output logic [2:0] light_S,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {MAIN_G, MAIN_Y, TURN_G, TURN_Y, SIDE_G, SIDE_Y, ALL_RED, FLASH} state_t;
    typedef enum logic [1:0] {NP_MAIN, NP_TURN, NP_SIDE} np_t;
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, DARK = 3'b000;

    state_t           state, state_nx;
    np_t              np, np_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             req_mt, req_s, blink;
    logic             req_mt_nx, req_s_nx, blink_nx, expired;

    function automatic logic [CNT_W-1:0] load(input state_t s);
        case (s)
            MAIN_G:                 return CNT_W'(T_MAIN - 1);
            TURN_G:                 return CNT_W'(T_TURN - 1);
            SIDE_G:                 return CNT_W'(T_SIDE - 1);
            MAIN_Y, TURN_Y, SIDE_Y: return CNT_W'(T_YELLOW - 1);
            ALL_RED:                return CNT_W'(T_ALLRED - 1);
            FLASH:                  return CNT_W'(T_BLINK - 1);
        endcase
    endfunction

    always_comb begin
        state_nx = state;
        np_nx    = np;
        blink_nx = blink;
        expired  = cnt == '0;
        case (state)
            MAIN_G: if (flash_en || (expired && (req_mt || req_s))) begin
                state_nx = MAIN_Y;
                np_nx    = req_mt ? NP_TURN : req_s ? NP_SIDE : NP_MAIN;
            end
            TURN_G: if (flash_en || expired) begin
                state_nx = TURN_Y;
                np_nx    = req_s ? NP_SIDE : NP_MAIN;
            end
            SIDE_G: if (flash_en || expired) begin
                state_nx = SIDE_Y;
                np_nx    = NP_MAIN;
            end
            MAIN_Y, TURN_Y, SIDE_Y: if (expired) state_nx = ALL_RED;
            ALL_RED: if (expired)
                state_nx = flash_en ? FLASH : np == NP_TURN ? TURN_G : np == NP_SIDE ? SIDE_G : MAIN_G;
            FLASH: if (!flash_en) begin
                state_nx = ALL_RED;
                np_nx    = NP_MAIN;
            end else if (expired) blink_nx = !blink;
        endcase
        // Rested MAIN_G parks the counter at zero; FLASH reloads it to pace the blink
        cnt_nx    = state_nx != state ? load(state_nx) : !expired ? cnt - CNT_W'(1) :
                    state == FLASH ? load(FLASH) : '0;
        req_mt_nx = (state_nx == TURN_G && state != TURN_G) ? 1'b0 : req_mt | (sensor_Mt && state != TURN_G);
        req_s_nx  = (state_nx == SIDE_G && state != SIDE_G) ? 1'b0 : req_s | (sensor_S && state != SIDE_G);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ALL_RED;
            cnt    <= CNT_W'(T_ALLRED - 1);
            np     <= NP_MAIN;
            req_mt <= 1'b0;
            req_s  <= 1'b0;
            blink  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            np     <= np_nx;
            req_mt <= req_mt_nx;
            req_s  <= req_s_nx;
            blink  <= blink_nx;
        end
    end

    always_comb begin
        light_M1 = RED;
        light_Mt = RED;
        light_M2 = RED;
        light_S  = RED;
        case (state)
            MAIN_G: begin light_M1 = GRN; light_M2 = GRN; end
            MAIN_Y: begin light_M1 = YEL; light_M2 = YEL; end
            TURN_G: begin light_M1 = GRN; light_Mt = GRN; end
            TURN_Y: begin light_M1 = YEL; light_Mt = YEL; end
            SIDE_G: light_S = GRN;
            SIDE_Y: light_S = YEL;
            FLASH: begin
                light_M1 = blink ? YEL : DARK;
                light_M2 = blink ? YEL : DARK;
                light_Mt = blink ? RED : DARK;
                light_S  = blink ? RED : DARK;
            end
            default: ;
        endcase
    end

    assign phase = state;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: segment tables expanded into a per-cycle scoreboard of phase and lamps
module tb_traffic_phase_controller;
    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000;
    localparam logic [11:0] L_MG = {G, R, G, R}, L_MY = {Y, R, Y, R}, L_TG = {G, G, R, R},
                            L_TY = {Y, Y, R, R}, L_SG = {R, R, R, G}, L_SY = {R, R, R, Y},
                            L_AR = {R, R, R, R}, L_FON = {Y, R, Y, R}, L_FOFF = {D, D, D, D};
    localparam logic [2:0] P_MG = 0, P_MY = 1, P_TG = 2, P_TY = 3, P_SG = 4, P_SY = 5, P_AR = 6, P_FL = 7;

    typedef struct {logic smt; logic ss; logic fl; logic [2:0] ph; logic [11:0] lt; int n;} vec_t;
    typedef struct {logic [2:0] ph; logic [11:0] lt; int id; int cyc;} exp_t;

    logic clk = 0, rst = 1, sensor_Mt = 0, sensor_S = 0, flash_en = 0;
    logic [2:0] light_M1, light_Mt, light_M2, light_S, phase;
    logic [11:0] lt;
    int checks = 0, errors = 0;
    vec_t vecs[$];
    exp_t exp_q[$];
    exp_t e;

    traffic_phase_controller #(.CNT_W(8), .T_MAIN(8), .T_TURN(4), .T_SIDE(6), .T_YELLOW(3),
                               .T_ALLRED(2), .T_BLINK(2)) dut (
        .clk(clk), .rst(rst), .sensor_Mt(sensor_Mt), .sensor_S(sensor_S), .flash_en(flash_en),
        .light_M1(light_M1), .light_Mt(light_Mt), .light_M2(light_M2), .light_S(light_S), .phase(phase)
    );

    assign lt = {light_M1, light_Mt, light_M2, light_S};
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (phase !== e.ph) begin
                errors++;
                $display("FAIL t%0d cyc%0d phase got %0d want %0d", e.id, e.cyc, phase, e.ph);
            end
            checks++;
            if (lt !== e.lt) begin
                errors++;
                $display("FAIL t%0d cyc%0d lights got %b want %b", e.id, e.cyc, lt, e.lt);
            end
        end
    end

    task automatic add(input logic smt, input logic ss, input logic fl, input logic [2:0] ph,
                       input logic [11:0] l, input int n);
        vecs.push_back('{smt, ss, fl, ph, l, n});
    endtask

    task automatic run(input int id);
        int cyc = 0;
        foreach (vecs[i])
            for (int k = 0; k < vecs[i].n; k++) begin
                sensor_Mt = vecs[i].smt;
                sensor_S  = vecs[i].ss;
                flash_en  = vecs[i].fl;
                exp_q.push_back('{vecs[i].ph, vecs[i].lt, id, cyc});
                cyc++;
                @(negedge clk);
            end
        vecs.delete();
        sensor_Mt = 0;
        sensor_S  = 0;
        flash_en  = 0;
    endtask

    task automatic do_reset(input int id);
        rst = 0;
        #1;
        checks++;
        if (phase !== P_AR) begin
            errors++;
            $display("FAIL t%0d reset phase got %0d want %0d", id, phase, P_AR);
        end
        checks++;
        if (lt !== L_AR) begin
            errors++;
            $display("FAIL t%0d reset lights got %b want %b", id, lt, L_AR);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        // Idle junction rests in MAIN_G
        do_reset(1);
        add(0, 0, 0, P_AR, L_AR, 1);
        add(0, 0, 0, P_MG, L_MG, 30);
        run(1);
        // Side request mid-green waits out the minimum green
        do_reset(2);
        add(0, 0, 0, P_AR, L_AR, 1);
        add(0, 0, 0, P_MG, L_MG, 3);
        add(0, 1, 0, P_MG, L_MG, 1);
        add(0, 0, 0, P_MG, L_MG, 4);
        add(0, 0, 0, P_MY, L_MY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_SG, L_SG, 6);
        add(0, 0, 0, P_SY, L_SY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_MG, L_MG, 12);
        run(2);
        // Turn and side both requested: turn first, then side
        do_reset(3);
        add(1, 1, 0, P_AR, L_AR, 1);
        add(0, 0, 0, P_MG, L_MG, 8);
        add(0, 0, 0, P_MY, L_MY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_TG, L_TG, 4);
        add(0, 0, 0, P_TY, L_TY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_SG, L_SG, 6);
        add(0, 0, 0, P_SY, L_SY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_MG, L_MG, 6);
        run(3);
        // Rested green reacts one edge after the request latches
        do_reset(4);
        add(0, 0, 0, P_AR, L_AR, 1);
        add(0, 0, 0, P_MG, L_MG, 20);
        add(1, 0, 0, P_MG, L_MG, 1);
        add(0, 0, 0, P_MY, L_MY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_TG, L_TG, 4);
        add(0, 0, 0, P_TY, L_TY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_MG, L_MG, 5);
        run(4);
        // Flash cuts the turn green short; side request latched during flash is served after
        do_reset(5);
        add(1, 0, 0, P_AR, L_AR, 1);
        add(0, 0, 0, P_MG, L_MG, 8);
        add(0, 0, 0, P_MY, L_MY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_TG, L_TG, 1);
        add(0, 0, 1, P_TY, L_TY, 3);
        add(0, 0, 1, P_AR, L_AR, 2);
        add(0, 0, 1, P_FL, L_FOFF, 2);
        add(0, 1, 1, P_FL, L_FON, 1);
        add(0, 0, 1, P_FL, L_FON, 1);
        add(0, 0, 1, P_FL, L_FOFF, 2);
        add(0, 0, 1, P_FL, L_FON, 2);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_MG, L_MG, 8);
        add(0, 0, 0, P_MY, L_MY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_SG, L_SG, 6);
        add(0, 0, 0, P_SY, L_SY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_MG, L_MG, 3);
        run(5);
        // Reset mid side green drops the pending turn request
        do_reset(6);
        add(0, 1, 0, P_AR, L_AR, 1);
        add(0, 0, 0, P_MG, L_MG, 8);
        add(0, 0, 0, P_MY, L_MY, 3);
        add(0, 0, 0, P_AR, L_AR, 2);
        add(0, 0, 0, P_SG, L_SG, 2);
        add(1, 0, 0, P_SG, L_SG, 1);
        run(6);
        do_reset(7);
        add(0, 0, 0, P_AR, L_AR, 1);
        add(0, 0, 0, P_MG, L_MG, 15);
        run(7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised, sensor-actuated successor to the fixed-cycle four-signal junction controller. It drives the main-road lights (M1, M2), the M1 turn light (Mt) and the side-road light (S) through a Moore state machine. Phase durations are set by parameters. Turn and side phases run only on a latched vehicle request, and a flash mode covers maintenance. It sits at junction top level, directly driving the lamp outputs.

## Interface
Parameters:
- CNT_W, 8: width of the phase down-counter; every duration parameter must be ≤ 2^CNT_W.
- T_MAIN, 20: minimum MAIN_G cycles.
- T_TURN, 8: TURN_G cycles.
- T_SIDE, 12: SIDE_G cycles.
- T_YELLOW, 4: cycles of every yellow state.
- T_ALLRED, 2: clearance cycles.
- T_BLINK, 5: half-period of the flash blink.
- All durations must be ≥ 1.

Ports (light encoding {red, yellow, green}: red=100, yellow=010, green=001, dark=000):
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sensor_Mt  in  1  vehicle waiting in turn lane (level or pulse, sampled every cycle).
- sensor_S  in  1  vehicle waiting on side road.
- flash_en  in  1  maintenance flash request (level).
- light_M1  out  3  main road, direction 1.
- light_Mt  out  3  main road, direction 1 turn.
- light_M2  out  3  main road, direction 2.
- light_S  out  3  side road.
- phase  out  3  current state code: MAIN_G=0, MAIN_Y=1, TURN_G=2, TURN_Y=3, SIDE_G=4, SIDE_Y=5, ALL_RED=6, FLASH=7.

## Operation
- Registers: state, down-counter cnt[CNT_W-1:0], next_phase {MAIN,TURN,SIDE}, req_Mt, req_S, blink.
- Entering a state with duration D loads cnt=D-1. The state expires on the cycle where cnt==0.
- Lights are decoded purely from state (and blink); unlisted lights are red.
  - MAIN_G: M1=M2=green.
  - MAIN_Y: M1=M2=yellow.
  - TURN_G: M1=Mt=green.
  - TURN_Y: M1=Mt=yellow.
  - SIDE_G: S=green.
  - SIDE_Y: S=yellow.
  - ALL_RED: all red.
  - FLASH: M1=M2 = yellow if blink else dark; Mt=S = red if blink else dark.
- Request latches:
  - req_Mt is set by sensor_Mt in any state except TURN_G and is cleared on entry to TURN_G.
  - req_S is set by sensor_S in any state except SIDE_G and is cleared on entry to SIDE_G.
  - A sensor high on the same cycle as the clear leaves the request cleared.
- Transitions (flash_en is checked first, everywhere):
  - MAIN_G: after expiry, it stays (cnt held at 0) until req_Mt|req_S|flash_en, then goes to MAIN_Y. next_phase = TURN if req_Mt, else SIDE.
  - TURN_G: on expiry → TURN_Y. next_phase = SIDE if req_S, else MAIN.
  - SIDE_G: on expiry → SIDE_Y. next_phase = MAIN.
  - Any green with flash_en=1 → its yellow on the next edge, ignoring remaining time.
  - Any yellow: on expiry → ALL_RED.
  - ALL_RED: on expiry → FLASH if flash_en, else the next_phase green.
  - FLASH: blink toggles each time cnt expires (reload T_BLINK-1). When flash_en=0 → ALL_RED with next_phase=MAIN.
- Flash never interrupts a yellow or ALL_RED. Request latches keep operating during FLASH.

## Timing
- Reset (rst=0, asynchronous) puts every register into this state:
  - state=ALL_RED, cnt=T_ALLRED-1, next_phase=MAIN.
  - req_Mt=req_S=0, blink=0.
  - All lights=100, phase=6.
- After release, ALL_RED lasts T_ALLRED rising edges, then MAIN_G.
- A state of duration D is held exactly D cycles.
- In a rested MAIN_G, a request sampled at edge k gives MAIN_Y visible after edge k+1.
- Outputs are registered-state Moore decodes: no combinational path from inputs to lights.
- Reset mid-operation clears all pending requests and immediately forces all-red.

## Test plan
Common parameters: T_MAIN=8, T_TURN=4, T_SIDE=6, T_YELLOW=3, T_ALLRED=2, T_BLINK=2.
- Reset, sensors low → ALL_RED (phase 6, all lights 100) for 2 cycles, then MAIN_G indefinitely with M1=M2=001 and Mt=S=100.
- 1-cycle sensor_S pulse at MAIN_G cycle 3 → MAIN_G 8, MAIN_Y 3, ALL_RED 2, SIDE_G 6, SIDE_Y 3, ALL_RED 2, then MAIN_G; req_S reads 0 after SIDE_G entry.
- sensor_Mt and sensor_S pulsed together in ALL_RED after reset → MAIN_G 8, then TURN path (M1=Mt=001 for 4 cycles), then SIDE_G 6, then MAIN_G.
- sensor_Mt pulse 20 cycles into a rested MAIN_G → MAIN_Y exactly one edge after the pulse is sampled.
- flash_en rises at TURN_G cycle 1 → TURN_Y next cycle (3 cycles), ALL_RED 2, then FLASH with M1 toggling 010/000 every 2 cycles. flash_en falls → ALL_RED 2, then MAIN_G; a sensor_S pulse during FLASH is served next.
- rst low mid-SIDE_G with req_Mt pending → lights 100 immediately; after release, MAIN_G follows with no turn phase.
